// File: rtl/abro_driver_if.sv
// Command, A/B/R/O pin, response and statistics signals of the ABRO driver.
// master = command source / controller side, slave = the driver itself.
interface abro_driver_if #(
    parameter int GAP_W = 8,
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [GAP_W-1:0] cmd_gap;
    logic             cmd_expect;
    logic             A;
    logic             B;
    logic             R;
    logic             O;
    logic             rsp_valid;
    logic             rsp_match;
    logic             rsp_o;
    logic             cnt_clr;
    logic [CNT_W-1:0] o_count;
    logic [CNT_W-1:0] mismatch_count;
    logic [CNT_W-1:0] spurious_count;

    modport master (
        output cmd_valid, cmd_op, cmd_gap, cmd_expect, O, cnt_clr,
        input  cmd_ready, A, B, R, rsp_valid, rsp_match, rsp_o,
               o_count, mismatch_count, spurious_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_gap, cmd_expect, O, cnt_clr,
        output cmd_ready, A, B, R, rsp_valid, rsp_match, rsp_o,
               o_count, mismatch_count, spurious_count
    );
endinterface

// File: rtl/abro_driver.sv
// Drives one-cycle A/B/R pulses per accepted command, checks O in the pulse
// cycle against the command's expectation and keeps saturating event counters.
module abro_driver #(
    parameter int GAP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    abro_driver_if.slave bus
);
    // state | meaning
    // IDLE  | cmd_ready high, waiting for a command
    // DRIVE | single cycle: A/B/R asserted, O sampled
    // GAP   | requested idle cycles, gap down-counter running
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             exp_q, exp_d;
    logic             a_q, a_d, b_q, b_d, r_q, r_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_match_q, rsp_match_d;
    logic             rsp_o_q, rsp_o_d;
    logic [CNT_W-1:0] o_cnt_q, o_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [CNT_W-1:0] spur_cnt_q, spur_cnt_d;
    logic             in_drive;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && !(&v)) return v + 1'b1;
        return v;
    endfunction

    assign in_drive = (state_q == S_DRIVE);

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        exp_d       = exp_q;
        a_d         = 1'b0;
        b_d         = 1'b0;
        r_d         = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_match_d = rsp_match_q;
        rsp_o_d     = rsp_o_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    // A/B/R are decided here so they are registered by the DRIVE cycle
                    gap_d   = bus.cmd_gap;
                    exp_d   = bus.cmd_expect;
                    a_d     = (bus.cmd_op == 2'b00) || (bus.cmd_op == 2'b11);
                    b_d     = (bus.cmd_op == 2'b01) || (bus.cmd_op == 2'b11);
                    r_d     = (bus.cmd_op == 2'b10);
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                rsp_valid_d = 1'b1;
                rsp_o_d     = bus.O;
                rsp_match_d = (bus.O == exp_q);
                if (gap_q != '0) begin
                    gap_cnt_d = gap_q;
                    state_d   = S_GAP;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_GAP: begin
                // terminal count at 1 so the counter lands on 0 and never wraps
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q == GAP_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_cnt_d    = o_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        spur_cnt_d = spur_cnt_q;
        if (bus.cnt_clr) begin
            o_cnt_d    = '0;
            mis_cnt_d  = '0;
            spur_cnt_d = '0;
        end else begin
            o_cnt_d    = sat_inc(o_cnt_q, in_drive & bus.O);
            mis_cnt_d  = sat_inc(mis_cnt_q, in_drive & (bus.O != exp_q));
            spur_cnt_d = sat_inc(spur_cnt_q, ~in_drive & bus.O);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            exp_q       <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            r_q         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_match_q <= 1'b0;
            rsp_o_q     <= 1'b0;
            o_cnt_q     <= '0;
            mis_cnt_q   <= '0;
            spur_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            exp_q       <= exp_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_match_q <= rsp_match_d;
            rsp_o_q     <= rsp_o_d;
            o_cnt_q     <= o_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
            spur_cnt_q  <= spur_cnt_d;
        end
    end

    assign bus.cmd_ready      = (state_q == S_IDLE);
    assign bus.A              = a_q;
    assign bus.B              = b_q;
    assign bus.R              = r_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_match      = rsp_match_q;
    assign bus.rsp_o          = rsp_o_q;
    assign bus.o_count        = o_cnt_q;
    assign bus.mismatch_count = mis_cnt_q;
    assign bus.spurious_count = spur_cnt_q;
endmodule
